// File: rtl/swat_le_loader.sv
// -----------------------------------------------------------------------------
// swat_le_loader
//
// Consumes the SWAT_LE software register in the user_clk domain. The 32-bit
// word from the PPC has to pass a stability filter before it is accepted.
// Rising edges of its load-enable bit (and, when built with the clear feature,
// its clear bit) become single-word writes or a full sweep-clear on the SWAT
// lookup-table port, which uses a ready handshake. It also counts completed
// loads and dropped load requests.
//
// Build option:
//   SWAT_LE_CLEAR_EN  define to include the clr bit, the CLEAR state and the
//                     sweep counter. When it is undefined, sw_reg[30] is
//                     ignored.
//
// Parameters:
//   ADDR_W         table address width (1..10), taken from sw_reg[20 +: ADDR_W]
//   DATA_W         table data width (1..20), taken from sw_reg[DATA_W-1:0]
//   STABLE_CYCLES  consecutive matching samples needed to accept a word (>=1)
//
// Ports:
//   user_clk    in   sole clock
//   user_rst_n  in   asynchronous active-low reset
//   sw_reg      in   [31] le, [30] clr, [29:20] addr, [19:0] data
//   tbl_ready   in   table accepts a write this cycle
//   tbl_we      out  write strobe; a write completes when tbl_we && tbl_ready
//   tbl_addr    out  write address
//   tbl_data    out  write data
//   busy        out  FSM not idle
//   load_count  out  completed load writes (wraps)
//   drop_count  out  dropped load requests (saturates at 255)
// -----------------------------------------------------------------------------
module swat_le_loader #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       sw_reg,
  input  logic              tbl_ready,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [DATA_W-1:0] tbl_data,
  output logic              busy,
  output logic [15:0]       load_count,
  output logic [7:0]        drop_count
);

  localparam int                CNT_W     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

`ifdef SWAT_LE_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLEAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE} state_t;
`endif

  // Stability filter and edge-detect state
  logic [31:0]       r_s0;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_acc;
  logic              r_le_d;
`ifdef SWAT_LE_CLEAR_EN
  logic              r_clr_d;
`endif

  // FSM and registered outputs
  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic [15:0]       r_load_count;
  logic [7:0]        r_drop_count;

  logic              w_le_rise;
  logic              w_drop;
  logic              w_unused;

  // A word is accepted only after it has been sampled identically on
  // STABLE_CYCLES+1 consecutive edges. Any change restarts the count.
  // NOTE: sequential state uses nonblocking (<=) assignments, so every
  // register here samples pre-edge values regardless of statement order.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_s0   <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_le_d <= 1'b0;
`ifdef SWAT_LE_CLEAR_EN
      r_clr_d <= 1'b0;
`endif
    end else begin
      r_s0 <= sw_reg;
      if (sw_reg != r_s0) begin
        r_cnt <= '0;
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_MAX) r_acc <= sw_reg;
      end
      r_le_d <= r_acc[31];
`ifdef SWAT_LE_CLEAR_EN
      r_clr_d <= r_acc[30];
`endif
    end
  end

  assign w_le_rise = r_acc[31] & ~r_le_d;

`ifdef SWAT_LE_CLEAR_EN
  logic w_clr_rise;
  assign w_clr_rise = r_acc[30] & ~r_clr_d;
  // A load request is lost if the FSM is busy, or if it coincides with a
  // clear request (the clear takes priority).
  assign w_drop     = w_le_rise & ((r_state != ST_IDLE) | w_clr_rise);
`else
  assign w_drop     = w_le_rise & (r_state == ST_WRITE);
`endif

  // Fields of the accepted word that the table port does not use.
  assign w_unused = ^r_acc;

  // The write strobe and the address/data are registered. They change only
  // when the FSM changes state or a write is accepted, so they stay stable
  // while the table holds off.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_load_count <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;

      unique case (r_state)
        ST_IDLE: begin
`ifdef SWAT_LE_CLEAR_EN
          if (w_clr_rise) begin
            r_state <= ST_CLEAR;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
          end else
`endif
          if (w_le_rise) begin
            r_state <= ST_WRITE;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_addr  <= r_acc[20 +: ADDR_W];
            r_data  <= r_acc[DATA_W-1:0];
          end
        end

        ST_WRITE: begin
          if (tbl_ready) begin
            r_load_count <= r_load_count + 16'd1;
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
          end
        end

`ifdef SWAT_LE_CLEAR_EN
        // tbl_addr doubles as the sweep counter; data stays zero.
        ST_CLEAR: begin
          if (tbl_ready) begin
            if (r_addr == ADDR_LAST) begin
              r_state <= ST_IDLE;
              r_we    <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tbl_we     = r_we;
  assign tbl_addr   = r_addr;
  assign tbl_data   = r_data;
  assign busy       = r_busy;
  assign load_count = r_load_count;
  assign drop_count = r_drop_count;

endmodule
